// File: rtl/ctrl_pipe_chain.sv
// Control-signal pipeline: ID instruction register plus STAGES valid-tagged
// control-bundle stages, with stall/flush bubble insertion and a bubble counter.
module ctrl_pipe_chain #(
    parameter int IW     = 32,
    parameter int CW     = 16,
    parameter int STAGES = 3    // legal range 2..8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IW-1:0]        if_instr,
    input  logic                 if_valid,
    output logic [IW-1:0]        id_instr,
    output logic                 id_valid,
    input  logic [CW-1:0]        cu_ctrl,
    input  logic                 stall,
    input  logic                 flush,
    output logic [STAGES*CW-1:0] stage_ctrl,
    output logic [STAGES-1:0]    stage_valid,
    output logic [15:0]          bubble_cnt
);

    logic [IW-1:0]        id_instr_q, id_instr_d;
    logic                 id_valid_q, id_valid_d;
    logic [STAGES*CW-1:0] stage_ctrl_q, stage_ctrl_d;
    logic [STAGES-1:0]    stage_valid_q, stage_valid_d;
    logic [15:0]          bubble_cnt_q, bubble_cnt_d;
    logic [CW-1:0]        stage0_ctrl_d;
    logic                 stage0_valid_d;
    logic                 issue;

    // An ID instruction advances into stage 0 only on a clean edge; otherwise a bubble enters.
    assign issue = !flush && !stall && id_valid_q;

    always_comb begin
        id_instr_d     = id_instr_q;
        id_valid_d     = id_valid_q;
        stage0_ctrl_d  = '0;
        stage0_valid_d = 1'b0;
        bubble_cnt_d   = bubble_cnt_q;

        if (flush) begin
            id_instr_d = '0;
            id_valid_d = 1'b0;
        end else if (!stall) begin
            id_instr_d = if_instr;
            id_valid_d = if_valid;
        end

        if (issue) begin
            stage0_ctrl_d  = cu_ctrl;
            stage0_valid_d = 1'b1;
        end

        // Only bubbles that delay a real instruction are counted.
        if (stall && !flush && id_valid_q && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    assign stage_ctrl_d[CW-1:0] = stage0_ctrl_d;
    assign stage_valid_d[0]     = stage0_valid_d;

    generate
        for (genvar gi = 1; gi < STAGES; gi++) begin : g_shift
            assign stage_ctrl_d[gi*CW +: CW] = stage_ctrl_q[(gi-1)*CW +: CW];
            assign stage_valid_d[gi]         = stage_valid_q[gi-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            id_instr_q    <= '0;
            id_valid_q    <= 1'b0;
            stage_ctrl_q  <= '0;
            stage_valid_q <= '0;
            bubble_cnt_q  <= '0;
        end else begin
            id_instr_q    <= id_instr_d;
            id_valid_q    <= id_valid_d;
            stage_ctrl_q  <= stage_ctrl_d;
            stage_valid_q <= stage_valid_d;
            bubble_cnt_q  <= bubble_cnt_d;
        end
    end

    assign id_instr    = id_instr_q;
    assign id_valid    = id_valid_q;
    assign stage_ctrl  = stage_ctrl_q;
    assign stage_valid = stage_valid_q;
    assign bubble_cnt  = bubble_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Randomized and directed bench for ctrl_pipe_chain against a queue-based
// reference model of the ID register and control-stage pipe.
module tb_ctrl_pipe_chain;

    localparam int IW = 32;
    localparam int CW = 16;
    localparam int ST = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [IW-1:0]     if_instr;
    logic              if_valid;
    logic [IW-1:0]     id_instr;
    logic              id_valid;
    logic [CW-1:0]     cu_ctrl;
    logic              stall;
    logic              flush;
    logic [ST*CW-1:0]  stage_ctrl;
    logic [ST-1:0]     stage_valid;
    logic [15:0]       bubble_cnt;

    always #5 clk = ~clk;

    ctrl_pipe_chain #(.IW(IW), .CW(CW), .STAGES(ST)) dut (
        .clk        (clk),
        .reset      (reset),
        .if_instr   (if_instr),
        .if_valid   (if_valid),
        .id_instr   (id_instr),
        .id_valid   (id_valid),
        .cu_ctrl    (cu_ctrl),
        .stall      (stall),
        .flush      (flush),
        .stage_ctrl (stage_ctrl),
        .stage_valid(stage_valid),
        .bubble_cnt (bubble_cnt)
    );

    typedef struct packed {
        logic [CW-1:0] c;
        logic          v;
    } ent_t;

    // Reference model: ID register, pipe as a queue (index 0 = EX), bubble count.
    ent_t          mq[$];
    logic [IW-1:0] m_id;
    logic          m_idv;
    int            m_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got %0h want %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_edge();
        ent_t e;
        if (reset) begin
            m_id  = '0;
            m_idv = 1'b0;
            m_cnt = 0;
            mq.delete();
            for (int i = 0; i < ST; i++) mq.push_back('0);
        end else begin
            e = '0;
            if (!flush && !stall && m_idv) begin
                e.c = cu_ctrl;
                e.v = 1'b1;
            end
            mq.push_front(e);
            void'(mq.pop_back());
            if (stall && !flush && m_idv && m_cnt < 65535) m_cnt++;
            if (flush) begin
                m_id  = '0;
                m_idv = 1'b0;
            end else if (!stall) begin
                m_id  = if_instr;
                m_idv = if_valid;
            end
        end
    endtask

    task automatic compare_all(input logic verbose);
        logic [ST*CW-1:0] exp_c;
        logic [ST-1:0]    exp_v;
        exp_c = '0;
        exp_v = '0;
        for (int i = 0; i < ST; i++) begin
            exp_c[i*CW +: CW] = mq[i].c;
            exp_v[i]          = mq[i].v;
        end
        chk("id_instr",    128'(id_instr),    128'(m_id));
        chk("id_valid",    128'(id_valid),    128'(m_idv));
        chk("stage_ctrl",  128'(stage_ctrl),  128'(exp_c));
        chk("stage_valid", 128'(stage_valid), 128'(exp_v));
        chk("bubble_cnt",  128'(bubble_cnt),  128'(m_cnt));
        if (verbose)
            $display("cyc=%0d rst=%0b stl=%0b fl=%0b id=%08h/%0b ctrl=%012h v=%03b cnt=%0d",
                     cyc, reset, stall, flush, id_instr, id_valid, stage_ctrl, stage_valid, bubble_cnt);
    endtask

    // Apply one cycle of inputs, advance model on the edge, compare 1 time unit later.
    task automatic drv(input logic r, input logic s, input logic f, input logic iv,
                       input logic [IW-1:0] ins, input logic verbose);
        reset    = r;
        stall    = s;
        flush    = f;
        if_valid = iv;
        if_instr = ins;
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        compare_all(verbose);
        // Control unit decodes the current ID instruction; garbage when ID is not valid.
        cu_ctrl = m_idv ? m_id[CW-1:0] : CW'($urandom);
    endtask

    localparam logic [IW-1:0] A = 32'hA000_0011;
    localparam logic [IW-1:0] B = 32'hB000_0022;
    localparam logic [IW-1:0] C = 32'hC000_0033;
    localparam logic [IW-1:0] D = 32'hD000_0044;

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        if_valid = 1'b0; if_instr = '0; cu_ctrl = '0;

        // Reset for two edges, then A, B.
        drv(1, 0, 0, 0, '0, 1);
        drv(1, 0, 0, 0, '0, 1);
        chk("reset_all", 128'({id_instr, id_valid, stage_ctrl, stage_valid, bubble_cnt}), 128'(0));
        drv(0, 0, 0, 1, A, 1);
        drv(0, 0, 0, 1, B, 1);
        chk("ex_is_A", 128'(stage_ctrl[CW-1:0]), 128'(16'h0011));
        // Stall two cycles while ID holds B.
        drv(0, 1, 0, 1, C, 1);
        drv(0, 1, 0, 1, C, 1);
        chk("stall_hold_B", 128'(id_instr), 128'(B));
        chk("stall_cnt2",   128'(bubble_cnt), 128'(2));
        chk("stall_A_ex2",  128'(stage_ctrl[2*CW +: CW]), 128'(16'h0011));
        drv(0, 0, 0, 1, C, 1);
        chk("B_into_ex", 128'(stage_ctrl[CW-1:0]), 128'(16'h0022));
        // Flush while ID holds C.
        drv(0, 0, 1, 1, D, 1);
        chk("flush_idv",   128'(id_valid), 128'(0));
        chk("flush_ex",    128'({stage_ctrl[CW-1:0], stage_valid[0]}), 128'(0));
        chk("flush_cnt",   128'(bubble_cnt), 128'(2));
        drv(0, 0, 0, 1, D, 1);
        drv(0, 0, 0, 1, A, 1);
        // Stall and flush together behave as flush.
        drv(0, 1, 1, 1, B, 1);
        chk("sf_idv", 128'(id_valid), 128'(0));
        chk("sf_cnt", 128'(bubble_cnt), 128'(2));
        drv(0, 0, 0, 1, B, 1);
        drv(0, 0, 0, 1, C, 1);
        drv(0, 0, 0, 1, D, 1);
        // Mid-stream reset with a full pipe.
        drv(1, 0, 0, 1, A, 1);
        chk("midrst_all", 128'({id_instr, id_valid, stage_ctrl, stage_valid, bubble_cnt}), 128'(0));
        // Idle stall: ID not valid, no count.
        drv(0, 1, 0, 1, A, 1);
        drv(0, 1, 0, 1, A, 1);
        chk("idle_stall_cnt", 128'(bubble_cnt), 128'(0));

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            drv(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 25),
                ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 80),
                IW'($urandom), 0);
        end

        // Saturation: load a valid instruction then stall past 16 bits.
        drv(1, 0, 0, 0, '0, 1);
        drv(0, 0, 0, 1, A, 1);
        for (int i = 0; i < 65540; i++) drv(0, 1, 0, 1, B, 0);
        chk("sat_ffff", 128'(bubble_cnt), 128'(16'hFFFF));
        drv(0, 1, 0, 1, B, 1);
        drv(0, 1, 0, 1, B, 1);
        chk("sat_hold", 128'(bubble_cnt), 128'(16'hFFFF));
        drv(0, 0, 0, 1, C, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
